// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR Fibonacci LFSR stream: maximal-length tap
// table, XNOR feedback helper and the output FSM state type.
package lfsr_pkg;

  localparam int LFSR_MAX_BITS = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_state_t;

  // Maximal-length XNOR tap mask for a given width; bit k set means state
  // bit k feeds the XNOR chain. Widths outside 3..32 return no taps.
  function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int width);
    logic [LFSR_MAX_BITS-1:0] mask;
    case (width)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  // XNOR chain over the tapped bits, taken from the highest tap downwards.
  function automatic logic lfsr_fb(input logic [LFSR_MAX_BITS-1:0] state,
                                   input logic [LFSR_MAX_BITS-1:0] taps);
    logic acc;
    logic first;
    acc   = 1'b0;
    first = 1'b1;
    for (int i = LFSR_MAX_BITS - 1; i >= 0; i--) begin
      if (taps[i]) begin
        if (first) begin
          acc   = state[i];
          first = 1'b0;
        end else begin
          acc = ~(acc ^ state[i]);
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/lfsr_stream_leap.sv
// Combinational leap-ahead: OUT_BITS single LFSR steps unrolled in one cycle.
// Also flags which intermediate post-step state equals the stored seed, so
// the top can detect that the sequence passed through its starting point.
module lfsr_leap
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int OUT_BITS = 8
) (
  input  logic [NUM_BITS-1:0] state,
  input  logic [NUM_BITS-1:0] seed,
  output logic [NUM_BITS-1:0] leap_state,
  output logic [OUT_BITS-1:0] match
);

  localparam logic [LFSR_MAX_BITS-1:0] TAP_MASK = lfsr_taps(NUM_BITS);

  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_step
    logic [NUM_BITS-1:0] prev;
    logic [NUM_BITS-1:0] nxt;

    if (gi == 0) begin : g_first
      assign prev = state;
    end else begin : g_rest
      assign prev = g_step[gi-1].nxt;
    end

    assign nxt      = {prev[NUM_BITS-2:0], lfsr_fb(LFSR_MAX_BITS'(prev), TAP_MASK)};
    assign match[gi] = (nxt == seed);
  end

  assign leap_state = g_step[OUT_BITS-1].nxt;

endmodule

// File: rtl/lfsr_stream.sv
// XNOR Fibonacci LFSR word source with valid/ready output, seed handshake,
// OUT_BITS-step leap per word, wrap flag and all-ones seed protection.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter int                  OUT_BITS = 8,
  parameter logic [NUM_BITS-1:0] RST_SEED = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic                i_seed_valid,
  input  logic [NUM_BITS-1:0] i_seed_data,
  output logic                o_seed_ready,
  output logic [OUT_BITS-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_wrap,
  output logic                o_seed_err,
  output logic [NUM_BITS-1:0] o_state
);

  fsm_state_t          fsm_reg;
  fsm_state_t          fsm_next;
  logic [NUM_BITS-1:0] state_reg;
  logic [NUM_BITS-1:0] seed_reg;
  logic [OUT_BITS-1:0] data_reg;
  logic                wrap_reg;
  logic                seed_err_reg;

  logic [NUM_BITS-1:0] leap_state;
  logic [OUT_BITS-1:0] match;
  logic                seed_load;
  logic                seed_ones;
  logic [NUM_BITS-1:0] seed_value;
  logic                advance;

  lfsr_leap #(
    .NUM_BITS(NUM_BITS),
    .OUT_BITS(OUT_BITS)
  ) u_leap (
    .state     (state_reg),
    .seed      (seed_reg),
    .leap_state(leap_state),
    .match     (match)
  );

  // The seed port never back-pressures, so an offered seed is always taken.
  assign o_seed_ready = 1'b1;
  assign seed_load    = i_seed_valid;
  // All-ones would freeze an XNOR LFSR; substitute zero instead.
  assign seed_ones    = &i_seed_data;
  assign seed_value   = seed_ones ? '0 : i_seed_data;
  assign advance      = i_enable && (!o_valid || i_ready) && !seed_load;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= S_IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  // Next state and valid: a seed flushes, a leap fills, a take empties.
  always_comb begin
    fsm_next = fsm_reg;
    o_valid  = (fsm_reg == S_RUN);
    if (seed_load) begin
      fsm_next = S_IDLE;
    end else if (advance) begin
      fsm_next = S_RUN;
    end else if ((fsm_reg == S_RUN) && i_ready) begin
      fsm_next = S_IDLE;
    end
  end

  // LFSR state, seed copy and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RST_SEED;
      seed_reg     <= RST_SEED;
      data_reg     <= '0;
      wrap_reg     <= 1'b0;
      seed_err_reg <= 1'b0;
    end else begin
      seed_err_reg <= seed_load && seed_ones;
      if (seed_load) begin
        state_reg <= seed_value;
        seed_reg  <= seed_value;
        data_reg  <= '0;
        wrap_reg  <= 1'b0;
      end else if (advance) begin
        state_reg <= leap_state;
        data_reg  <= leap_state[OUT_BITS-1:0];
        wrap_reg  <= |match;
      end
    end
  end

  assign o_data     = data_reg;
  assign o_wrap     = wrap_reg;
  assign o_seed_err = seed_err_reg;
  assign o_state    = state_reg;

endmodule
